pipeline_hazard_controller: RTL and testbench

- Sequences the pipeline register enables for a 5-stage in-order core.
- Drives IFIDControl on the IF/ID register, plus PC write, IF/ID flush, ID/EX bubble and a global memory freeze.
- Handles load-use stalls, multi-cycle multiply stalls held in ID, taken-branch flushes from EX, and data-memory wait states.
- Sits beside the decode stage and is the only block allowed to gate the pipeline registers.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/load_use_detector.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e : controller state (RUN, MUL_BUSY)
//   REG_ZERO   : hard-wired zero register; writes to it never create hazards
//   NOP_INSTR  : encoding that IF/ID flush and ID/EX bubble consumers load
//   CNT_W      : width of the multiply stall down-counter
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_e;

  localparam int unsigned REG_ZERO  = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned CNT_W     = 8;

endpackage

// File: rtl/load_use_detector.sv
// Pure comparator flagging a load-use hazard between the load in EX and the
// instruction in ID.
//   idex_memread, idex_rd      : load in EX and its destination
//   id_rs, id_rt, id_uses_rt   : sources of the instruction in ID
//   lu                         : ID must wait one cycle for the load data
module load_use_detector
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  lu
);

  localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

  assign lu = idex_memread && (idex_rd != RZ) &&
              ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline register enable sequencer for a 5-stage in-order core.
// Priority (highest first): reset, data-memory freeze, taken branch in EX,
// multiply stall in progress, load-use stall, multiply launch.
//   clk, reset                         : clock, synchronous active-high reset
//   id_*                               : instruction in ID
//   idex_memread, idex_rd              : instruction in EX
//   ex_branch_taken                    : branch/jump in EX resolved taken
//   exmem_memaccess, dmem_ready        : data memory handshake in MEM
//   pcWrite, IFIDControl, IFIDFlush,
//   IDEXBubble, memFreeze              : pipeline register controls
//   mulStart, mulCancel                : multiplier launch / abort pulses
//   stallCycles                        : saturating count of pcWrite=0 cycles
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int REG_ADDR_W  = 5,
  parameter int PERF_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_mul,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  exmem_memaccess,
  input  logic                  dmem_ready,
  output logic                  pcWrite,
  output logic                  IFIDControl,
  output logic                  IFIDFlush,
  output logic                  IDEXBubble,
  output logic                  memFreeze,
  output logic                  mulStart,
  output logic                  mulCancel,
  output logic [PERF_W-1:0]     stallCycles
);

  hz_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_q, stall_d;
  logic               lu;
  logic               freeze;

  load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .lu           (lu)
  );

  assign freeze = exmem_memaccess && !dmem_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcWrite     = 1'b1;
    IFIDControl = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    memFreeze   = 1'b0;
    mulStart    = 1'b0;
    mulCancel   = 1'b0;
    if (reset) begin
      pcWrite     = 1'b0;
      IFIDControl = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (freeze) begin
      // Whole pipeline holds; state, counter and any taken branch wait.
      memFreeze   = 1'b1;
      pcWrite     = 1'b0;
      IFIDControl = 1'b0;
    end else if (ex_branch_taken) begin
      // Wrong-path instructions in IF and ID are squashed, including a
      // multiply waiting in ID, so an in-flight multiply is aborted.
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      if (state_q == MUL_BUSY) begin
        mulCancel = 1'b1;
        state_d   = RUN;
        cnt_d     = '0;
      end
    end else if (state_q == MUL_BUSY) begin
      if (cnt_q != '0) begin
        pcWrite     = 1'b0;
        IFIDControl = 1'b0;
        IDEXBubble  = 1'b1;
        cnt_d       = cnt_q - 1'b1;
      end else begin
        // Release cycle: the multiply moves to EX with default enables.
        state_d = RUN;
      end
    end else if (lu) begin
      pcWrite     = 1'b0;
      IFIDControl = 1'b0;
      IDEXBubble  = 1'b1;
    end else if (id_is_mul) begin
      // Launch cycle is the first of MUL_LATENCY stall cycles.
      mulStart    = 1'b1;
      pcWrite     = 1'b0;
      IFIDControl = 1'b0;
      IDEXBubble  = 1'b1;
      cnt_d       = CNT_W'(MUL_LATENCY - 1);
      state_d     = MUL_BUSY;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (reset)                          stall_d = '0;
    else if (!pcWrite && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    stall_q <= stall_d;
  end

  assign stallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int L   = 4;
  localparam int RW  = 5;
  localparam int PW  = 5;
  localparam int SAT = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, idex_rd;
  logic          id_uses_rt, id_is_mul, idex_memread;
  logic          ex_branch_taken, exmem_memaccess, dmem_ready;
  logic          pcWrite, IFIDControl, IFIDFlush, IDEXBubble;
  logic          memFreeze, mulStart, mulCancel;
  logic [PW-1:0] stallCycles;
  logic [6:0]    ctl;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  // reference model state: multiply active, stall cycles spent, stall counter
  bit   m_busy;
  int   m_done;
  int   m_stall;
  bit   n_busy;
  int   n_done;
  int   n_stall;
  logic [6:0] exp_ctl;

  pipeline_hazard_controller #(.MUL_LATENCY(L), .REG_ADDR_W(RW), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_mul(id_is_mul), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken), .exmem_memaccess(exmem_memaccess),
    .dmem_ready(dmem_ready), .pcWrite(pcWrite), .IFIDControl(IFIDControl),
    .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble), .memFreeze(memFreeze),
    .mulStart(mulStart), .mulCancel(mulCancel), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  // {pcWrite, IFIDControl, IFIDFlush, IDEXBubble, memFreeze, mulStart, mulCancel}
  assign ctl = {pcWrite, IFIDControl, IFIDFlush, IDEXBubble, memFreeze, mulStart, mulCancel};

  task automatic idle();
    reset = 1'b0; id_rs = '0; id_rt = '0; idex_rd = '0; id_uses_rt = 1'b0;
    id_is_mul = 1'b0; idex_memread = 1'b0; ex_branch_taken = 1'b0;
    exmem_memaccess = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one cycle of the controller from its rules.
  function automatic void model_eval();
    bit lu_m;
    lu_m = idex_memread && idex_rd != 0 &&
           (idex_rd == id_rs || (id_uses_rt && idex_rd == id_rt));
    exp_ctl = 7'b1100000;
    n_busy  = m_busy;
    n_done  = m_done;
    if (reset) begin
      exp_ctl = 7'b0011000; n_busy = 1'b0; n_done = 0;
    end else if (exmem_memaccess && !dmem_ready) begin
      exp_ctl = 7'b0000100;
    end else if (ex_branch_taken) begin
      exp_ctl = m_busy ? 7'b1111001 : 7'b1111000;
      n_busy  = 1'b0;
    end else if (m_busy) begin
      if (m_done < L) begin exp_ctl = 7'b0001000; n_done = m_done + 1; end
      else n_busy = 1'b0;
    end else if (lu_m) begin
      exp_ctl = 7'b0001000;
    end else if (id_is_mul) begin
      exp_ctl = 7'b0001010; n_busy = 1'b1; n_done = 1;
    end
    if (reset)                          n_stall = 0;
    else if (!exp_ctl[6] && m_stall < SAT) n_stall = m_stall + 1;
    else                                n_stall = m_stall;
  endfunction

  task automatic test_reset();
    idle(); reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 7'b0011000) begin
        errors++; $display("FAIL reset_outputs c%0d: got %b want 0011000", c, ctl);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("FAIL reset_release_ctl: got %b want 1100000", ctl);
    end
    checks++;
    if (stallCycles !== PW'(0)) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stallCycles);
    end
    tick();
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    idle(); idex_memread = 1'b1; idex_rd = 5'd3; id_rs = 5'd3;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0001000) begin
      errors++; $display("FAIL load_use_stall: got %b want 0001000", ctl);
    end
    tick(); exp_stall++;
    idle(); idex_memread = 1'b1; idex_rd = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(exp_stall)) begin
      errors++; $display("FAIL load_use_count: got %0d want %0d", stallCycles, exp_stall);
    end
    checks++;
    if (ctl !== 7'b1100000) begin
      errors++; $display("FAIL load_use_r0: got %b want 1100000", ctl);
    end
    tick(); idle();
  endtask

  task automatic test_mul();
    logic [6:0] want;
    idle(); id_is_mul = 1'b1;
    for (int c = 0; c <= L; c++) begin
      @(negedge clk);
      want = (c == 0) ? 7'b0001010 : (c < L) ? 7'b0001000 : 7'b1100000;
      checks++;
      if (ctl !== want) begin
        errors++; $display("FAIL mul_seq c%0d: got %b want %b", c, ctl, want);
      end
      tick();
    end
    exp_stall += L;
    idle();
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(exp_stall)) begin
      errors++; $display("FAIL mul_count: got %0d want %0d", stallCycles, exp_stall);
    end
    tick();
  endtask

  task automatic test_branch_cancel();
    idle(); id_is_mul = 1'b1;
    tick();                        // launch, counter loads L-1
    id_is_mul = 1'b0;
    tick();                        // counter now 2
    ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1111001) begin
      errors++; $display("FAIL branch_cancel: got %b want 1111001", ctl);
    end
    tick();
    ex_branch_taken = 1'b0; id_is_mul = 1'b1;
    @(negedge clk);
    checks++;                      // a fresh launch proves the controller is back in RUN
    if (ctl !== 7'b0001010) begin
      errors++; $display("FAIL branch_back_to_run: got %b want 0001010", ctl);
    end
    tick();
    id_is_mul = 1'b0;
    repeat (L) tick();
    exp_stall += 2 + L;
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(exp_stall)) begin
      errors++; $display("FAIL branch_count: got %0d want %0d", stallCycles, exp_stall);
    end
    tick();
  endtask

  task automatic test_freeze();
    logic [6:0] want;
    idle(); id_is_mul = 1'b1;
    tick();
    id_is_mul = 1'b0;
    tick();                        // counter now 2
    exmem_memaccess = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ex_branch_taken = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl !== 7'b0000100) begin
        errors++; $display("FAIL freeze c%0d: got %b want 0000100", c, ctl);
      end
      tick();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      want = (c < 2) ? 7'b0001000 : 7'b1100000;
      @(negedge clk);
      checks++;
      if (ctl !== want) begin
        errors++; $display("FAIL freeze_resume c%0d: got %b want %b", c, ctl, want);
      end
      tick();
    end
    exp_stall += 7;
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(exp_stall)) begin
      errors++; $display("FAIL freeze_count: got %0d want %0d", stallCycles, exp_stall);
    end
    tick();
  endtask

  task automatic test_lu_mul();
    idle(); idex_memread = 1'b1; idex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    id_rs = 5'd1; id_is_mul = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0001000) begin
      errors++; $display("FAIL lu_mul_defer: got %b want 0001000", ctl);
    end
    tick();
    idex_memread = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0001010) begin
      errors++; $display("FAIL lu_mul_launch: got %b want 0001010", ctl);
    end
    tick();
    idle();
    repeat (L) tick();
    exp_stall += 1 + L;
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(exp_stall)) begin
      errors++; $display("FAIL lu_mul_count: got %0d want %0d", stallCycles, exp_stall);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    m_busy = 1'b0; m_done = 0; m_stall = exp_stall;
    for (int i = 0; i < n; i++) begin
      reset           = ($urandom_range(63) == 0);
      exmem_memaccess = ($urandom_range(3) == 0);
      dmem_ready      = ($urandom_range(3) != 0);
      ex_branch_taken = ($urandom_range(7) == 0);
      id_is_mul       = ($urandom_range(3) == 0);
      idex_memread    = ($urandom_range(2) == 0);
      id_uses_rt      = ($urandom_range(1) == 0);
      idex_rd         = RW'($urandom_range(3));
      id_rs           = RW'($urandom_range(3));
      id_rt           = RW'($urandom_range(3));
      @(negedge clk);
      model_eval();
      checks++;
      if (ctl !== exp_ctl) begin
        errors++; $display("FAIL random_ctl i%0d: got %b want %b", i, ctl, exp_ctl);
      end
      checks++;
      if (stallCycles !== PW'(m_stall)) begin
        errors++; $display("FAIL random_count i%0d: got %0d want %0d", i, stallCycles, m_stall);
      end
      @(posedge clk);
      m_busy = n_busy; m_done = n_done; m_stall = n_stall;
      #1;
    end
  endtask

  task automatic test_saturation();
    idle(); idex_memread = 1'b1; idex_rd = 5'd2; id_rs = 5'd2;
    repeat (SAT + 10) tick();
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(SAT)) begin
      errors++; $display("FAIL sat_reach: got %0d want %0d", stallCycles, SAT);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stallCycles !== PW'(SAT)) begin
      errors++; $display("FAIL sat_nowrap: got %0d want %0d", stallCycles, SAT);
    end
    tick(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle(); reset = 1'b1;
    test_reset();
    test_load_use();
    test_mul();
    test_branch_cancel();
    test_freeze();
    test_lu_mul();
    test_random(400);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
